updown_modn_counter: RTL
========================

# updown_modn_counter

Runtime-programmable modulo-N counter with up/down direction, count enable, synchronous load, and cascade outputs. It is the general-purpose successor to the fixed-modulus up counter. Modulus and width are no longer baked in at elaboration, so one instance can serve clock dividers, timers, and multi-digit cascaded counters (e.g. BCD chains).

## Interface
- WIDTH, default 8: counter and modulus bit-width.
- RST_VAL, default 0: value loaded into count on reset. Must be < 2^WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable. One step per clk edge while high.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- mod_n  input  WIDTH  modulus. 0 means 2^WIDTH (full range).
- load  input  1  synchronous load request.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count / carry-out, combinational: en & at-terminal.
- wrap  output  1  registered one-cycle pulse after a wrap occurred.
- load_err  output  1  registered one-cycle pulse after an out-of-range load.

## Operation
- Effective maximum: max = mod_n − 1, computed modulo 2^WIDTH. So mod_n = 0 gives max = 2^WIDTH − 1.
- Priority per clk edge is rst > load > en > hold.
- rst:
  - count = RST_VAL; wrap = 0; load_err = 0.
- load (not rst):
  - If load_val ≤ max, count = load_val.
  - Otherwise count = 0 and load_err = 1 for one cycle.
  - en is ignored in that cycle; wrap = 0.
- en, up_dn = 1:
  - If count ≥ max, count = 0 and wrap = 1.
  - Otherwise count = count + 1.
- en, up_dn = 0:
  - If count = 0, count = max and wrap = 1.
  - If count > max, count = max and wrap = 0 (resync after a modulus shrink).
  - Otherwise count = count − 1.
- Hold (no rst/load/en): count unchanged; wrap = 0; load_err = 0.
- At-terminal: (up_dn & count ≥ max) | (~up_dn & count = 0).
- tc = en & at-terminal & ~load & ~rst.
  - Feed tc straight into the en input of the next stage to cascade.
  - Cascaded stages share the same clk.
- mod_n is sampled every cycle and may change at any time. No handshake.
  - Up mode: a count above the new max wraps to 0 on the next enabled edge.
  - Down mode: a count above the new max clamps to max on the next enabled edge.
- mod_n = 1 (max = 0): count stays at 0. Every enabled edge wraps, so tc = en.
- Arithmetic is unsigned, WIDTH bits, no overflow outside the explicit wrap rules.
- up_dn may toggle on any cycle and takes effect on the same edge.

## Timing
- Latency:
  - count changes exactly one clk edge after the enabling condition is sampled.
  - wrap and load_err go high in the cycle after the edge that caused the wrap or bad load, and last one cycle.
- tc is combinational from en, up_dn, load, rst, mod_n, and count.
  - No registered path.
  - Downstream logic samples it on the same edge at which this stage wraps.
- Reset: all outputs take their reset values on the first rising edge with rst = 1.
  - tc evaluates to 0 while rst = 1.
- Reset mid-count overrides load and en in the same cycle. A wrap that would have happened is lost, and wrap stays 0.
- Load and en together: load wins, no step is taken, tc = 0.
- Back-to-back wraps (mod_n = 1, en held high) give wrap = 1 continuously, starting one cycle after en rises.

## Test plan
- Up count, WIDTH = 4, mod_n = 10, en = 1 after reset:
  - count 0,1,…,9,0,…
  - tc = 1 only while count = 9.
  - wrap high in the cycle with count = 0 after each rollover.
- Down count, mod_n = 6, load_val = 2 loaded, then en = 1, up_dn = 0:
  - count 2,1,0,5,4,…
  - tc = 1 while count = 0.
  - wrap pulses once per rollover to 5.
- Bad load, mod_n = 10, load_val = 12:
  - count = 0 and load_err = 1 for exactly one cycle.
  - load_val = 9 with en = 1 in the same cycle gives count = 9, no increment.
- Modulus shrink, count = 8, mod_n changed 10 → 5:
  - Up: next enabled edge gives count = 0 and wrap = 1.
  - Repeat in down mode: count = 4, wrap = 0.
- Full range and degenerate modulus:
  - mod_n = 0, WIDTH = 4: count runs 0…15 then wraps; tc at 15.
  - mod_n = 1: count stays 0, tc = en, wrap continuous.
- Cascade of two WIDTH = 4, mod_n = 10 stages (stage1.en = stage0.tc) over 100 enabled cycles:
  - Reads 99 after 99 cycles.
  - Returns to 00 at cycle 100, with both wraps pulsing together.
  - rst asserted mid-run returns both stages to RST_VAL on the next edge.

Source files
------------

// File: rtl/updown_modn_counter_if.sv
// Bundle of control inputs and status outputs for the programmable up/down modulo-N counter.
// The master side drives the controls; the counter itself attaches as the slave.
interface updown_modn_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] mod_n;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up_dn, mod_n, load, load_val,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, mod_n, load, load_val,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/updown_modn_counter.sv
// Runtime-programmable modulo-N up/down counter with synchronous load and cascade outputs.
// Priority on each edge is reset, then load, then enable, then hold.
module updown_modn_counter #(
    parameter int WIDTH   = 8,
    parameter int RST_VAL = 0
) (
    input logic                   clk,
    input logic                   rst,
    updown_modn_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] max_val;
    logic             at_term;

    // mod_n of zero wraps around to the full 2^WIDTH range
    assign max_val = bus.mod_n - ONE;
    assign at_term = bus.up_dn ? (count_q >= max_val) : (count_q == ZERO);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (bus.load_val <= max_val) begin
                count_d = bus.load_val;
            end else begin
                count_d    = ZERO;
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count_q >= max_val) begin
                    count_d = ZERO;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                // A count left above a freshly shrunk modulus clamps down without flagging a wrap
                if (count_q == ZERO) begin
                    count_d = max_val;
                    wrap_d  = 1'b1;
                end else if (count_q > max_val) begin
                    count_d = max_val;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= RST_V;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.tc       = bus.en & at_term & ~bus.load & ~rst;
endmodule
